// File: rtl/tt_pkg.sv
// tt_pkg: shared definitions for truth_table_sweeper.
//   tt_state_e      - sweep FSM states (IDLE, HOLD, SAMPLE, FIN)
//   num_vectors(n)  - number of input combinations for n inputs (2^n)
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } tt_state_e;

  function automatic int num_vectors(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter with a zero flag. It times the HOLD
// interval of the sweeper. The count stops at zero instead of wrapping.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset (count -> 0)
//   load     - load load_val (has priority over en)
//   load_val - value to load
//   en       - decrement while nonzero
//   zero     - count == 0
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives a small combinational circuit through every
// input combination, lets each settle, samples the response and compares it
// against an expected truth table latched at start.
// Optional feature: define TT_CAPTURE_EN to add the 'captured' output holding
// the raw sampled response of every vector.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   start        - request a sweep (accepted only in IDLE)
//   expected     - expected truth table, bit i = response for vector i
//   stim         - vector driven to the circuit (stim[0] = x1)
//   resp         - circuit response
//   busy         - sweep in progress (start acceptance up to, not incl., done)
//   done         - one-cycle end-of-sweep pulse
//   pass         - last sweep had zero mismatches
//   err_count    - mismatch count of the last sweep
//   fail_valid   - at least one mismatch recorded
//   first_fail   - lowest failing vector index (valid with fail_valid)
//   captured     - (TT_CAPTURE_EN) sampled response per vector
module truth_table_sweeper import tt_pkg::*; #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [num_vectors(N_IN)-1:0] expected,
  output logic [N_IN-1:0]              stim,
  input  logic                         resp,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [N_IN:0]                err_count,
  output logic                         fail_valid,
  output logic [N_IN-1:0]              first_fail
`ifdef TT_CAPTURE_EN
  ,
  output logic [num_vectors(N_IN)-1:0] captured
`endif
);

  localparam int NV = num_vectors(N_IN);
  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0]  SETTLE_LOAD = TW'(SETTLE - 1);
  // One bit wider than stim so comparing against the last index never wraps.
  localparam logic [N_IN:0]  LAST_VEC    = (N_IN + 1)'(NV - 1);
  localparam logic [N_IN:0]  ONE         = (N_IN + 1)'(1);

  tt_state_e state_q, state_d;

  logic [NV-1:0]   expected_q;
  logic [N_IN:0]   vec_q;
  logic [N_IN:0]   err_q;
  logic [N_IN:0]   err_next;
  logic            pass_q;
  logic            fail_valid_q;
  logic [N_IN-1:0] first_fail_q;
  logic            tmr_load;
  logic            tmr_en;
  logic            tmr_zero;
  logic            mismatch;
  logic            last_vec;

  settle_timer #(.W(TW)) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign mismatch = (resp != expected_q[stim]);
  assign last_vec = (vec_q == LAST_VEC);
  // Includes the vector being sampled, so pass reflects the final vector too.
  assign err_next = mismatch ? (err_q + ONE) : err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
        end
      end
      HOLD: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (last_vec) begin
          state_d = FIN;
        end else begin
          state_d  = HOLD;
          tmr_load = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the latched truth table is reset along with the rest; it is only a
  // few flops and this keeps every output deterministic out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q   <= '0;
      vec_q        <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        expected_q   <= expected;
        vec_q        <= '0;
        err_q        <= '0;
        pass_q       <= 1'b0;
        fail_valid_q <= 1'b0;
        first_fail_q <= '0;
      end else if (state_q == SAMPLE) begin
        err_q <= err_next;
        if (mismatch && !fail_valid_q) begin
          fail_valid_q <= 1'b1;
          first_fail_q <= stim;
        end
        // stim stays on the last index after the sweep.
        if (last_vec) pass_q <= (err_next == '0);
        else          vec_q  <= vec_q + ONE;
      end
    end
  end

`ifdef TT_CAPTURE_EN
  logic [NV-1:0] captured_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      captured_q <= '0;
    end else if (state_q == IDLE && start) begin
      captured_q <= '0;
    end else if (state_q == SAMPLE) begin
      captured_q[stim] <= resp;
    end
  end

  assign captured = captured_q;
`endif

  assign stim       = vec_q[N_IN-1:0];
  assign busy       = (state_q == HOLD) || (state_q == SAMPLE);
  assign done       = (state_q == FIN);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a SETTLE=1 instance driving a
// selectable gate (constant 0 or x1|x2) and a SETTLE=3 instance driving x1&x2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] expected;
  logic [1:0] stim;
  logic       resp;
  logic       busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] first_fail;
  logic       resp_or;

  logic       start3;
  logic [3:0] expected3;
  logic [1:0] stim3;
  logic       resp3;
  logic       busy3, done3, pass3, fail_valid3;
  logic [2:0] err_count3;
  logic [1:0] first_fail3;
`ifdef TT_CAPTURE_EN
  logic [3:0] captured, captured3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Circuits under check.
  assign resp  = resp_or ? (stim[0] | stim[1]) : 1'b0;
  assign resp3 = stim3[0] & stim3[1];

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .expected   (expected),
    .stim       (stim),
    .resp       (resp),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .first_fail (first_fail)
`ifdef TT_CAPTURE_EN
    ,
    .captured   (captured)
`endif
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .expected   (expected3),
    .stim       (stim3),
    .resp       (resp3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .err_count  (err_count3),
    .fail_valid (fail_valid3),
    .first_fail (first_fail3)
`ifdef TT_CAPTURE_EN
    ,
    .captured   (captured3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic p, input logic [2:0] ec,
                               input logic fv, input logic [1:0] ff);
    check({tag, " pass"},       pass,       p);
    check({tag, " err_count"},  err_count,  ec);
    check({tag, " fail_valid"}, fail_valid, fv);
    check({tag, " first_fail"}, first_fail, ff);
  endtask

  // Full SETTLE=1 sweep. Returns at the falling edge of the done cycle.
  // poke > 0 pulses start (with a different table) in that sweep cycle.
  task automatic run_sweep(input string tag, input logic [3:0] exp_tt, input int poke);
    @(negedge clk);
    start    = 1'b1;
    expected = exp_tt;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      if (k == poke) begin
        start    = 1'b1;
        expected = 4'b0000;
      end else if (k == poke + 1) begin
        start = 1'b0;
      end
      if (k <= 8) check($sformatf("%s stim c%0d", tag, k), stim, (k - 1) / 2);
      check($sformatf("%s busy c%0d", tag, k), busy, (k < 9));
      check($sformatf("%s done c%0d", tag, k), done, (k == 9));
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    expected  = 4'b0000;
    resp_or   = 1'b0;
    start3    = 1'b0;
    expected3 = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset stim", stim, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check_results("reset", 1'b0, 3'd0, 1'b0, 2'd0);
    rst = 1'b0;

    // All-zero circuit against an all-zero table.
    run_sweep("zero", 4'b0000, 0);
    check_results("zero", 1'b1, 3'd0, 1'b0, 2'd0);
    @(negedge clk);
    check("zero done pulse", done, 0);
    check("zero idle stim",  stim, 3);
    check("zero pass held",  pass, 1);

    // All-zero circuit against XOR: vectors 1 and 2 mismatch.
    run_sweep("xor", 4'b0110, 0);
    check_results("xor", 1'b0, 3'd2, 1'b1, 2'd1);

    // OR circuit: matching table, then AND-like table.
    resp_or = 1'b1;
    run_sweep("or_ok", 4'b1110, 0);
    check_results("or_ok", 1'b1, 3'd0, 1'b0, 2'd0);
    run_sweep("or_bad", 4'b1000, 0);
    check_results("or_bad", 1'b0, 3'd2, 1'b1, 2'd1);

    // Start (and a new table) during a sweep is ignored.
    run_sweep("poke", 4'b1110, 3);
    check_results("poke", 1'b1, 3'd0, 1'b0, 2'd0);
    // start held high in the done cycle must not launch a sweep.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done-cycle start busy", busy, 0);
    check("done-cycle start done", done, 0);

    // Reset during vector 2 discards the sweep.
    resp_or = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    expected = 4'b0110;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);   // now in cycle 5: vector 2 HOLD
    check("pre-rst stim", stim, 2);
    check("pre-rst err",  err_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst stim", stim, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check_results("rst", 1'b0, 3'd0, 1'b0, 2'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rst no done %0d", k), done, 0);
    end
    run_sweep("after_rst", 4'b0110, 0);
    check_results("after_rst", 1'b0, 3'd2, 1'b1, 2'd1);

    // SETTLE=3 instance, AND circuit.
    @(negedge clk);
    start3    = 1'b1;
    expected3 = 4'b1000;
    @(negedge clk);
    start3 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 16) check($sformatf("s3 stim c%0d", k), stim3, (k - 1) / 4);
      check($sformatf("s3 busy c%0d", k), busy3, (k < 17));
      check($sformatf("s3 done c%0d", k), done3, (k == 17));
    end
    check("s3 pass",       pass3,       1);
    check("s3 err_count",  err_count3,  0);
    check("s3 fail_valid", fail_valid3, 0);
`ifdef TT_CAPTURE_EN
    check("s3 captured", captured3, 4'b1000);
    @(negedge clk);
    check("s3 captured held", captured3, 4'b1000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
